// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared opcode/funct/ALU encodings, multicycle FSM states and static control bundle
package cpu_types_pkg;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
    OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F
  } opcode_t;
  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
    F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B
  } funct_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED} mc_state_t;
  typedef enum logic [2:0] {CL_ALU, CL_BR, CL_MEM, CL_JMP, CL_HALT} iclass_t;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] SRC_REG = 2'b00, SRC_SHAMT = 2'b01, SRC_IMM = 2'b10;
  localparam logic [1:0] JS_NPC = 2'b00, JS_BR = 2'b01, JS_JR = 2'b10, JS_J = 2'b11;
  typedef struct packed {
    logic [1:0] regdest;
    logic [1:0] alusrc;
    logic [1:0] jumpsel;
    logic       extop;
    logic       memtoreg;
    logic       lui;
    logic       jal;
    aluop_t     aluop;
    iclass_t    cls;
  } ctl_t;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: memory handshake (instr/ihit/dhit/zero in) and datapath control/status bundle; master = control unit, slave = memory/datapath
interface mc_control_unit_if import cpu_types_pkg::*; #(parameter int CNT_W = 32);
  logic [31:0]      instr;
  logic             ihit, dhit, zero;
  logic             iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite;
  logic [1:0]       RegDest, ALUSrc, JumpSel;
  logic             ExtOP, MemtoReg, LUI, JAL;
  aluop_t           ALUOP;
  logic [4:0]       Rs, Rt, Rd;
  logic [31:0]      shamt;
  logic [15:0]      Imm;
  logic             halt, illegal, timeout;
  logic [CNT_W-1:0] retired;
  modport master (
    input  instr, ihit, dhit, zero,
    output iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite, RegDest, ALUSrc, JumpSel, ExtOP,
           MemtoReg, LUI, JAL, ALUOP, Rs, Rt, Rd, shamt, Imm, halt, illegal, timeout, retired
  );
  modport slave (
    output instr, ihit, dhit, zero,
    input  iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite, RegDest, ALUSrc, JumpSel, ExtOP,
           MemtoReg, LUI, JAL, ALUOP, Rs, Rt, Rd, shamt, Imm, halt, illegal, timeout, retired
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct -> static controls, instruction class and valid flag (i_op, i_fn in; o_ctl, o_valid out)
module mc_decode import cpu_types_pkg::*; #(
  parameter bit IMM_SIGNED_SLTIU = 1'b1
) (
  input  logic [5:0] i_op,
  input  logic [5:0] i_fn,
  output ctl_t       o_ctl,
  output logic       o_valid
);
  always_comb begin
    o_ctl = '0;
    o_ctl.aluop = ALU_ADD;
    o_valid = 1'b1;
    o_ctl.regdest = i_op == OP_RTYPE ? RD_RD : RD_RT;
    o_ctl.alusrc = i_op == OP_RTYPE ? SRC_REG : SRC_IMM;
    case (i_op)
      OP_RTYPE:
        case (i_fn)
          F_SLL: begin o_ctl.aluop = ALU_SLL; o_ctl.alusrc = SRC_SHAMT; end
          F_SRL: begin o_ctl.aluop = ALU_SRL; o_ctl.alusrc = SRC_SHAMT; end
          F_ADD, F_ADDU: o_ctl.aluop = ALU_ADD;
          F_SUB, F_SUBU: o_ctl.aluop = ALU_SUB;
          F_AND: o_ctl.aluop = ALU_AND;
          F_OR: o_ctl.aluop = ALU_OR;
          F_XOR: o_ctl.aluop = ALU_XOR;
          F_NOR: o_ctl.aluop = ALU_NOR;
          F_SLT: o_ctl.aluop = ALU_SLT;
          F_SLTU: o_ctl.aluop = ALU_SLTU;
          F_JR: begin o_ctl.cls = CL_JMP; o_ctl.jumpsel = JS_JR; end
          default: o_valid = 1'b0;
        endcase
      OP_J: begin o_ctl.cls = CL_JMP; o_ctl.jumpsel = JS_J; end
      OP_JAL: begin o_ctl.cls = CL_JMP; o_ctl.jumpsel = JS_J; o_ctl.jal = 1'b1; o_ctl.regdest = RD_RA; end
      OP_BEQ, OP_BNE: begin o_ctl.cls = CL_BR; o_ctl.jumpsel = JS_BR; o_ctl.alusrc = SRC_REG; o_ctl.aluop = ALU_SUB; o_ctl.extop = 1'b1; end
      OP_ADDI, OP_ADDIU: o_ctl.extop = 1'b1;
      OP_SLTI: begin o_ctl.aluop = ALU_SLT; o_ctl.extop = 1'b1; end
      OP_SLTIU: begin o_ctl.aluop = ALU_SLTU; o_ctl.extop = IMM_SIGNED_SLTIU; end
      OP_ANDI: o_ctl.aluop = ALU_AND;
      OP_ORI: o_ctl.aluop = ALU_OR;
      OP_XORI: o_ctl.aluop = ALU_XOR;
      OP_LUI: o_ctl.lui = 1'b1;
      OP_LW: begin o_ctl.cls = CL_MEM; o_ctl.memtoreg = 1'b1; o_ctl.extop = 1'b1; end
      OP_SW: begin o_ctl.cls = CL_MEM; o_ctl.extop = 1'b1; end
      OP_HALT: o_ctl.cls = CL_HALT;
      default: o_valid = 1'b0;
    endcase
    if (!o_valid) o_ctl = '0;
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with IR, wait timeout and retired counter (CLK, nRST, bus: mc_control_unit_if.master)
module mc_control_unit import cpu_types_pkg::*; #(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W = 32,
  parameter bit IMM_SIGNED_SLTIU = 1'b1
) (
  input logic CLK,
  input logic nRST,
  mc_control_unit_if.master bus
);
  localparam int WW = $clog2(WAIT_MAX + 2);
  localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX > 0 ? WAIT_MAX - 1 : 0);
  mc_state_t        r_state;
  logic [31:0]      r_ir;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_timeout;
  ctl_t             w_ctl;
  logic             w_valid, w_act, w_hit, w_to, w_last, w_taken;
  mc_decode #(.IMM_SIGNED_SLTIU(IMM_SIGNED_SLTIU)) u_dec (
    .i_op(r_ir[31:26]), .i_fn(r_ir[5:0]), .o_ctl(w_ctl), .o_valid(w_valid)
  );
  always_comb begin
    w_act = r_state inside {DECODE, EXEC, MEM, WB};
    w_hit = (r_state == FETCH && bus.ihit) || (r_state == MEM && bus.dhit);
    // the cycle that would bring wait_cnt up to WAIT_MAX times out, unless a hit lands in it
    w_to = WAIT_MAX > 0 && r_state inside {FETCH, MEM} && !w_hit && r_wait == WLIM;
    // BEQ/BNE differ only in opcode bit 0
    w_taken = bus.zero ^ r_ir[26];
    w_last = (r_state == DECODE && (!w_valid || w_ctl.cls == CL_JMP)) ||
             (r_state == EXEC && w_ctl.cls == CL_BR) ||
             (r_state == MEM && bus.dhit && !w_ctl.memtoreg) || r_state == WB;
    bus.iREN = r_state == FETCH;
    bus.IRWrite = r_state == FETCH && bus.ihit;
    bus.dREN = r_state == MEM && w_ctl.memtoreg;
    bus.dWEN = r_state == MEM && !w_ctl.memtoreg;
    bus.PCWrite = w_last;
    bus.RegWrite = r_state == WB || (r_state == DECODE && w_valid && w_ctl.jal);
    bus.illegal = r_state == DECODE && !w_valid;
    bus.RegDest = w_act ? w_ctl.regdest : 2'b00;
    bus.ALUSrc = w_act ? w_ctl.alusrc : 2'b00;
    bus.ExtOP = w_act && w_ctl.extop;
    bus.MemtoReg = w_act && w_ctl.memtoreg;
    bus.LUI = w_act && w_ctl.lui;
    bus.JAL = w_act && w_ctl.jal;
    bus.ALUOP = w_act ? w_ctl.aluop : ALU_SLL;
    bus.JumpSel = !w_act ? JS_NPC : (r_state == EXEC && w_ctl.cls == CL_BR) ? (w_taken ? JS_BR : JS_NPC) : w_ctl.jumpsel;
    bus.Rs = r_ir[25:21];
    bus.Rt = r_ir[20:16];
    bus.Rd = r_ir[15:11];
    bus.shamt = {27'b0, r_ir[10:6]};
    bus.Imm = r_ir[15:0];
    bus.halt = r_state == HALTED;
    bus.timeout = r_timeout;
    bus.retired = r_retired;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ir <= '0;
      r_wait <= '0;
      r_retired <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= (r_state inside {FETCH, MEM} && !w_hit) ? r_wait + 1'b1 : '0;
      r_retired <= r_retired + CNT_W'(w_last);
      if (w_to) r_timeout <= 1'b1;
      if (bus.IRWrite) r_ir <= bus.instr;
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: r_state <= bus.ihit ? DECODE : w_to ? HALTED : FETCH;
        DECODE: r_state <= (!w_valid || w_ctl.cls == CL_JMP) ? FETCH : w_ctl.cls == CL_HALT ? HALTED : EXEC;
        EXEC: r_state <= w_ctl.cls == CL_BR ? FETCH : w_ctl.cls == CL_MEM ? MEM : WB;
        MEM: r_state <= bus.dhit ? (w_ctl.memtoreg ? WB : FETCH) : w_to ? HALTED : MEM;
        WB: r_state <= FETCH;
        default: r_state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction stream against a per-instruction reference model with queued expectations
module tb_mc_control_unit;
  import cpu_types_pkg::*;
  localparam int WM = 4;
  localparam int CW = 4;
  typedef struct {logic [31:0] w; int di; int dd; bit z;} stim_t;
  typedef struct {
    int kind, cyc, nd, nw;
    bit rw, ex, m2r, lui, jal, ill, chk;
    logic [1:0] rd, as, js;
    aluop_t op;
    logic [CW-1:0] ret;
  } exp_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  mc_control_unit_if #(.CNT_W(CW)) bus ();
  mc_control_unit #(.WAIT_MAX(WM), .CNT_W(CW), .IMM_SIGNED_SLTIU(1'b1)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  stim_t sq[$];
  exp_t eq[$];
  int pass_n = 0;
  int tot_n = 0;
  logic [CW-1:0] nret = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask
  function automatic exp_t model(input logic [31:0] w, input int di, input int dd, input bit z, input logic [CW-1:0] r);
    exp_t e;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    e.kind = 0; e.cyc = di + 4; e.nd = 0; e.nw = 0; e.rw = 1; e.ex = 0; e.m2r = 0; e.lui = 0;
    e.jal = 0; e.ill = 0; e.chk = 1; e.rd = 2'b01; e.as = 2'b00; e.js = 2'b00; e.op = ALU_ADD; e.ret = r;
    if (op == 6'h00) begin
      case (fn)
        6'h00: begin e.op = ALU_SLL; e.as = 2'b01; end
        6'h02: begin e.op = ALU_SRL; e.as = 2'b01; end
        6'h20, 6'h21: e.op = ALU_ADD;
        6'h22, 6'h23: e.op = ALU_SUB;
        6'h24: e.op = ALU_AND;
        6'h25: e.op = ALU_OR;
        6'h26: e.op = ALU_XOR;
        6'h27: e.op = ALU_NOR;
        6'h2A: e.op = ALU_SLT;
        6'h2B: e.op = ALU_SLTU;
        6'h08: begin e.cyc = di + 2; e.rw = 0; e.chk = 0; e.js = 2'b10; end
        default: begin e.cyc = di + 2; e.rw = 0; e.chk = 0; e.ill = 1; end
      endcase
    end else begin
      e.rd = 2'b00; e.as = 2'b10; e.ex = 1;
      case (op)
        6'h02: begin e.cyc = di + 2; e.rw = 0; e.chk = 0; e.js = 2'b11; end
        6'h03: begin e.cyc = di + 2; e.rd = 2'b10; e.jal = 1; e.chk = 0; e.js = 2'b11; end
        6'h04: begin e.cyc = di + 3; e.rw = 0; e.chk = 0; e.js = z ? 2'b01 : 2'b00; end
        6'h05: begin e.cyc = di + 3; e.rw = 0; e.chk = 0; e.js = z ? 2'b00 : 2'b01; end
        6'h08, 6'h09: e.op = ALU_ADD;
        6'h0A: e.op = ALU_SLT;
        6'h0B: e.op = ALU_SLTU;
        6'h0C: begin e.op = ALU_AND; e.ex = 0; end
        6'h0D: begin e.op = ALU_OR; e.ex = 0; end
        6'h0E: begin e.op = ALU_XOR; e.ex = 0; end
        6'h0F: begin e.lui = 1; e.chk = 0; end
        6'h23: begin e.cyc = di + dd + 5; e.m2r = 1; e.nd = dd + 1; end
        6'h2B: begin e.cyc = di + dd + 4; e.rw = 0; e.nw = dd + 1; end
        6'h3F: begin e.kind = 1; e.cyc = di + 2; e.rw = 0; e.chk = 0; end
        default: begin e.cyc = di + 2; e.rw = 0; e.chk = 0; e.ill = 1; end
      endcase
    end
    return e;
  endfunction
  task automatic add(input logic [31:0] w, input int di, input int dd, input bit z);
    exp_t e;
    sq.push_back('{w, di, dd, z});
    e = model(w, di, dd, z, nret);
    eq.push_back(e);
    if (e.kind == 0) nret = nret + 1'b1;
  endtask
  // memory side: answers each fetch/data request after the delay carried by the instruction
  initial begin
    stim_t cur;
    int fk, dk;
    cur = '{32'h0, 0, 0, 1'b0};
    fk = 0; dk = 0;
    bus.instr = '0; bus.ihit = 1'b0; bus.dhit = 1'b0; bus.zero = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.ihit = 1'b0;
      bus.dhit = 1'b0;
      if (bus.iREN && sq.size() > 0 && fk == sq[0].di) begin
        bus.ihit = 1'b1;
        bus.instr = sq[0].w;
        cur = sq.pop_front();
      end
      fk = bus.iREN ? fk + 1 : 0;
      if (bus.dREN || bus.dWEN) begin
        bus.dhit = dk == cur.dd;
        dk++;
      end else dk = 0;
      bus.zero = cur.z;
    end
  end
  // monitor: per-instruction observation, compared when the instruction retires or halts
  initial begin
    exp_t e;
    int cyc, n_ill, n_dr, n_dw, n_irw;
    bit infl, ph;
    cyc = 0; n_ill = 0; n_dr = 0; n_dw = 0; n_irw = 0; infl = 0; ph = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        infl = 0;
        ph = 0;
      end else if (bus.halt && !ph) begin
        ph = 1;
        infl = 0;
        if (eq.size() == 0) begin
          tot_n++;
          $display("FAIL halt_unexpected: got halt expected no pending item");
        end else begin
          e = eq.pop_front();
          chk("halt_kind", 32'(e.kind != 0), 32'(1));
          chk("halt_cycles", 32'(cyc), 32'(e.cyc));
          chk("halt_timeout", 32'(bus.timeout), 32'(e.kind == 2));
          chk("halt_retired", 32'(bus.retired), 32'(e.ret));
        end
      end else if (!bus.halt) begin
        if (bus.iREN && !infl) begin
          infl = 1; cyc = 0; n_ill = 0; n_dr = 0; n_dw = 0; n_irw = 0;
        end
        if (infl) begin
          cyc++;
          n_ill += int'(bus.illegal);
          n_dr += int'(bus.dREN);
          n_dw += int'(bus.dWEN);
          n_irw += int'(bus.IRWrite);
        end
        if (bus.PCWrite) begin
          infl = 0;
          if (eq.size() == 0) begin
            tot_n++;
            $display("FAIL retire_unexpected: got PCWrite expected no pending item");
          end else begin
            e = eq.pop_front();
            chk("retire_kind", 32'(e.kind), 32'(0));
            chk("cycles", 32'(cyc), 32'(e.cyc));
            chk("irwrite_cnt", 32'(n_irw), 32'(1));
            chk("illegal_cnt", 32'(n_ill), 32'(e.ill));
            chk("dren_cnt", 32'(n_dr), 32'(e.nd));
            chk("dwen_cnt", 32'(n_dw), 32'(e.nw));
            chk("regwrite", 32'(bus.RegWrite), 32'(e.rw));
            chk("jumpsel", 32'(bus.JumpSel), 32'(e.js));
            chk("memtoreg", 32'(bus.MemtoReg), 32'(e.m2r));
            chk("lui", 32'(bus.LUI), 32'(e.lui));
            chk("jal", 32'(bus.JAL), 32'(e.jal));
            chk("retired", 32'(bus.retired), 32'(e.ret));
            if (e.rw) chk("regdest", 32'(bus.RegDest), 32'(e.rd));
            if (e.chk) begin
              chk("alusrc", 32'(bus.ALUSrc), 32'(e.as));
              chk("extop", 32'(bus.ExtOP), 32'(e.ex));
              chk("aluop", 32'(bus.ALUOP), 32'(e.op));
            end
          end
        end
      end
    end
  end
  task automatic wait_halt(input string nm);
    for (int i = 0; i < 4000 && !bus.halt; i++) @(negedge CLK);
    if (!bus.halt) begin
      tot_n++;
      $display("FAIL %s: got no halt expected halt within 4000 cycles", nm);
    end
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, "_iREN"}, 32'(bus.iREN), 32'(0));
    chk({nm, "_dREN"}, 32'(bus.dREN | bus.dWEN), 32'(0));
    chk({nm, "_PCWrite"}, 32'(bus.PCWrite | bus.RegWrite | bus.IRWrite), 32'(0));
    chk({nm, "_ctrl"}, 32'({bus.RegDest, bus.ALUSrc, bus.JumpSel, bus.ALUOP}), 32'(0));
  endtask
  initial begin
    logic [5:0] ops[18] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                            6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3E};
    logic [5:0] fns[14] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};
    logic [31:0] w;
    exp_t e;
    repeat (2) @(posedge CLK);
    #1;
    chk_quiet("reset");
    chk("reset_retired", 32'(bus.retired), 32'(0));
    chk("reset_halt", 32'(bus.halt | bus.timeout | bus.illegal), 32'(0));
    add({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 0, 0, 1'b0);
    add({6'h23, 5'd1, 5'd4, 16'h0010}, 0, 3, 1'b0);
    add({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1'b1);
    add({6'h04, 5'd1, 5'd2, 16'h0004}, 1, 0, 1'b0);
    add({6'h05, 5'd1, 5'd2, 16'h0008}, 0, 0, 1'b0);
    add({6'h3E, 26'h0000123}, 0, 0, 1'b0);
    add({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 2, 0, 1'b0);
    add({6'h2B, 5'd2, 5'd5, 16'h0020}, 3, 2, 1'b0);
    add({6'h03, 26'h0000400}, 0, 0, 1'b0);
    add({6'h0B, 5'd1, 5'd2, 16'h8000}, 3, 0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      w = {ops[$urandom_range(17)], 26'($urandom)};
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(13)];
      add(w, $urandom_range(3), $urandom_range(3), 1'($urandom));
    end
    add({6'h3F, 26'h0}, 1, 0, 1'b0);
    nRST = 1'b1;
    wait_halt("halt_wait");
    @(negedge CLK);
    chk("queue_drained", 32'(eq.size()), 32'(0));
    chk("retired_final", 32'(bus.retired), 32'(nret));
    chk_quiet("halted");
    chk("halted_timeout", 32'(bus.timeout), 32'(0));
    e = model({6'h3F, 26'h0}, 0, 0, 1'b0, '0);
    e.kind = 2;
    e.cyc = WM;
    eq.push_back(e);
    @(posedge CLK);
    #3 nRST = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_halt", 32'(bus.halt | bus.timeout), 32'(0));
    chk("async_rst_retired", 32'(bus.retired), 32'(0));
    @(posedge CLK);
    #2 nRST = 1'b1;
    #1 chk("idle_iREN", 32'(bus.iREN), 32'(0));
    @(posedge CLK);
    #1 chk("fetch_iREN", 32'(bus.iREN), 32'(1));
    wait_halt("timeout_wait");
    repeat (3) @(negedge CLK);
    chk("timeout_sticky", 32'(bus.timeout), 32'(1));
    chk("halt_sticky", 32'(bus.halt), 32'(1));
    chk_quiet("timeout_halted");
    nRST = 1'b0;
    #1 chk("rst_clears_timeout", 32'(bus.timeout | bus.halt), 32'(0));
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
